// File: rtl/key_event_queue.sv
// Key event queue: detects ps2Key toggles, buffers {pressed, extended, scancode} in a FIFO and
// replays them as kstrobe pulses at least GAP cycles apart. Optional: KEYQ_REPEAT_FILTER_EN.
module key_event_queue #(
    parameter int unsigned DEPTH = 8,
    parameter logic [15:0] GAP   = 16'd1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [10:0]             ps2Key,
    input  logic                    clear,
    output logic                    kstrobe,
    output logic                    kpress,
    output logic                    kext,
    output logic [7:0]              kcode,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

    typedef enum logic {StIdle, StWait} state_e;

    logic              toggle_q, arm_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    state_e            state_q, state_d;
    logic [15:0]       gap_q, gap_d;
    logic              kstrobe_q, kstrobe_d;
    logic              kpress_q, kpress_d, kext_q, kext_d;
    logic [7:0]        kcode_q, kcode_d;
    logic [9:0]        mem_q [DEPTH];
    logic [9:0]        head;
    logic              event_in, full, pop, is_repeat, push_req, push, drop;

    // The first edge after reset only arms the toggle register.
    assign event_in = arm_q && (ps2Key[10] != toggle_q) && !clear;
    assign full     = (count_q == DepthCnt);
    assign pop      = (state_q == StIdle) && (count_q != '0) && !clear;
    assign head     = mem_q[rd_ptr_q];

`ifdef KEYQ_REPEAT_FILTER_EN
    logic       filt_valid_q, filt_valid_d;
    logic [8:0] filt_key_q, filt_key_d;

    assign is_repeat = ps2Key[9] && filt_valid_q && (filt_key_q == ps2Key[8:0]);

    always_comb begin
        filt_valid_d = filt_valid_q;
        filt_key_d   = filt_key_q;
        if (clear) begin
            filt_valid_d = 1'b0;
        end else if (event_in) begin
            if (ps2Key[9]) begin
                if (push) begin
                    filt_valid_d = 1'b1;
                    filt_key_d   = ps2Key[8:0];
                end
            end else if (filt_valid_q && (filt_key_q == ps2Key[8:0])) begin
                filt_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filt_valid_q <= 1'b0;
            filt_key_q   <= '0;
        end else begin
            filt_valid_q <= filt_valid_d;
            filt_key_q   <= filt_key_d;
        end
    end
`else
    assign is_repeat = 1'b0;
`endif

    // A full FIFO still accepts a write when the head is popped on the same edge.
    assign push_req = event_in && !is_repeat;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW+1)'(1);
            else if (pop && !push) count_d = count_q - (AW+1)'(1);
            if (drop) overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        kstrobe_d = 1'b0;
        kpress_d  = kpress_q;
        kext_d    = kext_q;
        kcode_d   = kcode_q;
        if (clear) begin
            state_d = StIdle;
            gap_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_d   = StWait;
                        gap_d     = GAP - 16'd1;
                        kstrobe_d = 1'b1;
                        kpress_d  = head[9];
                        kext_d    = head[8];
                        kcode_d   = head[7:0];
                    end
                end
                StWait: begin
                    // Leave on the edge the counter reaches zero so strobes are exactly GAP apart.
                    if (gap_q <= 16'd1) begin
                        gap_d   = '0;
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q - 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            toggle_q   <= 1'b0;
            arm_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
            gap_q      <= '0;
            kstrobe_q  <= 1'b0;
            kpress_q   <= 1'b0;
            kext_q     <= 1'b0;
            kcode_q    <= 8'h00;
        end else begin
            toggle_q   <= ps2Key[10];
            arm_q      <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            gap_q      <= gap_d;
            kstrobe_q  <= kstrobe_d;
            kpress_q   <= kpress_d;
            kext_q     <= kext_d;
            kcode_q    <= kcode_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= ps2Key[9:0];
    end

    assign kstrobe  = kstrobe_q && !clear;
    assign kpress   = kpress_q;
    assign kext     = kext_q;
    assign kcode    = kcode_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
